// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the execute-stage units.
//   - WIDTH_DEF / SHAMT_W_DEF : default datapath and shift-amount widths
//   - OP_SLL / OP_SRL / OP_SRA: shift-unit op encodings (2'b10 is reserved and
//                               executes as SLL)
//   - state_t                 : shift-unit FSM state encoding
package mips_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/seq_shift_unit_shift_step.sv
// shift_step: combinational single-bit shifter feeding the result register.
// Ports:
//   d  in  WIDTH  value to shift
//   op in  2      OP_SLL / OP_SRL / OP_SRA (reserved 2'b10 behaves as SLL)
//   q  out WIDTH  d shifted by exactly one bit position
module shift_step
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] q
);

  // One-bit shift; SRA copies the current MSB into the vacated position.
  always_comb begin
    q = d;
    case (op)
      OP_SRL:  q = {1'b0, d[WIDTH-1:1]};
      OP_SRA:  q = {d[WIDTH-1], d[WIDTH-1:1]};
      OP_SLL:  q = {d[WIDTH-2:0], 1'b0};
      default: q = {d[WIDTH-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle SLL/SRL/SRA unit, one bit per clock.
// Ports:
//   clk     in  1        rising-edge clock
//   reset   in  1        asynchronous active-high reset
//   start   in  1        request, sampled only while idle
//   op      in  2        00 SLL, 01 SRL, 11 SRA, 10 reserved (as SLL)
//   data_in in  WIDTH    operand
//   shamt   in  SHAMT_W  shift amount, 0..WIDTH-1
//   busy    out 1        high while an operation is in flight (incl. done cycle)
//   done    out 1        one-cycle pulse, result valid
//   result  out WIDTH    shifted value, held until the next accepted start
// Latency is shamt+1 cycles; all outputs come straight from flops.
module seq_shift_unit
  import mips_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic [SHAMT_W-1:0] count_r;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   result_r;
  logic [WIDTH-1:0]   step_s;
  logic               busy_r;
  logic               done_r;

  // The result register is its own shift source: one step per SHIFT cycle.
  shift_step #(
    .WIDTH(WIDTH)
  ) u_shift_step (
    .d (result_r),
    .op(op_r),
    .q (step_s)
  );

  // FSM, shift datapath and registered busy/done; busy/done are set on the
  // transition into the state they decode so they track state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      count_r  <= CNT_ZERO;
      op_r     <= OP_SLL;
      result_r <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            result_r <= data_in;
            op_r     <= op;
            count_r  <= shamt;
            busy_r   <= 1'b1;
            if (shamt != CNT_ZERO) begin
              state_r <= SHIFT;
              done_r  <= 1'b0;
            end else begin
              // Zero shift skips SHIFT; data_in is already the answer.
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end

        SHIFT: begin
          result_r <= step_s;
          // count is >= 1 here, so the decrement never wraps.
          count_r  <= count_r - CNT_ONE;
          busy_r   <= 1'b1;
          if (count_r == CNT_ONE) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            done_r  <= 1'b0;
          end
        end

        DONE: begin
          // start is deliberately ignored here; no queuing.
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end

        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule
